// File: rtl/phase_gen_pkg.sv
// Shared FSM type and default sizing for the transducer phase generator.
package phase_gen_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDrain
   } phase_state_e;

   localparam int unsigned DefNumCh  = 8;
   localparam int unsigned DefPeriod = 25;
   localparam int unsigned DefCntW   = 5;
   localparam int unsigned DefChW    = 3;
   localparam int unsigned Half      = DefPeriod / 2;

   function automatic int unsigned half_of(input int unsigned period);
      return period / 2;
   endfunction

endpackage

// File: rtl/phase_gen_ch.sv
// One transducer channel: active phase register and modular compare that
// yields the un-registered drive bit for the current period count.
module phase_gen_ch
   import phase_gen_pkg::*;
#(
   parameter int unsigned PERIOD = DefPeriod,
   parameter int unsigned CNT_W  = DefCntW
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_phase,
   input  logic [CNT_W-1:0] i_cnt,
   output logic             o_drive
);

   localparam logic [CNT_W:0] LimPeriod = (CNT_W+1)'(PERIOD);
   localparam logic [CNT_W:0] LimHalf   = (CNT_W+1)'(half_of(PERIOD));

   logic [CNT_W-1:0] r_phase;
   logic [CNT_W:0]   w_diff;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_phase <= '0;
      end else if (i_load) begin
         r_phase <= i_phase;
      end
   end

   // Distance of the count past this channel's phase, modulo PERIOD.
   always_comb begin
      if (i_cnt >= r_phase) begin
         w_diff = {1'b0, i_cnt} - {1'b0, r_phase};
      end else begin
         w_diff = {1'b0, i_cnt} + LimPeriod - {1'b0, r_phase};
      end
      o_drive = (w_diff < LimHalf);
   end

endmodule

// File: rtl/transducer_phase_gen.sv
// Multi-channel phased square-wave generator stepped by clock_divider's slow
// clock. Optional per-channel output mask is enabled by PHASE_GEN_MASK_EN.
module transducer_phase_gen
   import phase_gen_pkg::*;
#(
   parameter int unsigned NUM_CH = DefNumCh,
   parameter int unsigned PERIOD = DefPeriod,
   parameter int unsigned CNT_W  = DefCntW,
   parameter int unsigned CH_W   = DefChW
) (
   input  logic              clock_in,
   input  logic              rst,
   input  logic              tick_in,
   input  logic              run,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [CH_W-1:0]   wr_ch,
   input  logic [CNT_W-1:0]  wr_phase,
   input  logic              commit,
`ifdef PHASE_GEN_MASK_EN
   input  logic              mask_valid,
   input  logic [NUM_CH-1:0] mask_data,
`endif
   output logic [NUM_CH-1:0] drive_out,
   output logic              sync_out,
   output logic              busy
);

   localparam logic [CNT_W-1:0] LastCnt = CNT_W'(PERIOD - 1);

   phase_state_e      r_state;
   phase_state_e      w_state_next;
   logic              r_tick_d;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_pending;
   logic [CNT_W-1:0]  r_shadow [NUM_CH];
   logic [NUM_CH-1:0] r_drive;
   logic              r_sync;

   logic              w_step;
   logic              w_wrap;
   logic              w_load;
   logic              w_accept;
   logic [CNT_W-1:0]  w_sat;
   logic [NUM_CH-1:0] w_pre;
   logic [NUM_CH-1:0] w_en;

   assign w_step   = tick_in & ~r_tick_d;
   assign w_wrap   = (r_state != StIdle) & w_step & (r_cnt == LastCnt);
   // Commit lands on a period boundary, or straight away when nothing is running.
   assign w_load   = r_pending & (w_wrap | (r_state == StIdle));
   assign w_accept = wr_valid & wr_ready;
   assign w_sat    = (wr_phase > LastCnt) ? LastCnt : wr_phase;

   always_ff @(posedge clock_in) begin
      if (!rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:  if (run) w_state_next = StRun;
         StRun:   if (!run) w_state_next = StDrain;
         StDrain: begin
            if (run) begin
               w_state_next = StRun;
            end else if (w_wrap) begin
               w_state_next = StIdle;
            end
         end
         default: w_state_next = StIdle;
      endcase
   end

   always_comb begin
      busy     = (r_state != StIdle);
      wr_ready = ~r_pending;
   end

   always_ff @(posedge clock_in) begin
      if (!rst) begin
         r_tick_d  <= 1'b0;
         r_cnt     <= '0;
         r_pending <= 1'b0;
         r_sync    <= 1'b0;
         r_drive   <= '0;
      end else begin
         r_tick_d <= tick_in;
         if (r_state == StIdle) begin
            r_cnt <= '0;
         end else if (w_step) begin
            r_cnt <= (r_cnt == LastCnt) ? '0 : r_cnt + 1'b1;
         end
         if (w_load) begin
            r_pending <= 1'b0;
         end else if (commit) begin
            r_pending <= 1'b1;
         end
         r_sync  <= w_wrap;
         r_drive <= (r_state == StIdle) ? '0 : (w_pre & w_en);
      end
   end

   // Writes to channels beyond NUM_CH match no entry and are dropped.
   always_ff @(posedge clock_in) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (!rst) begin
            r_shadow[i] <= '0;
         end else if (w_accept && (wr_ch == CH_W'(i))) begin
            r_shadow[i] <= w_sat;
         end
      end
   end

`ifdef PHASE_GEN_MASK_EN
   logic [NUM_CH-1:0] r_mask_shadow;
   logic [NUM_CH-1:0] r_mask_active;

   always_ff @(posedge clock_in) begin
      if (!rst) begin
         r_mask_shadow <= '1;
         r_mask_active <= '1;
      end else begin
         if (mask_valid) r_mask_shadow <= mask_data;
         if (w_load) r_mask_active <= r_mask_shadow;
      end
   end

   assign w_en = r_mask_active;
`else
   assign w_en = '1;
`endif

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      phase_gen_ch #(
         .PERIOD(PERIOD),
         .CNT_W (CNT_W)
      ) u_ch (
         .i_clk  (clock_in),
         .i_rst_n(rst),
         .i_load (w_load),
         .i_phase(r_shadow[g]),
         .i_cnt  (r_cnt),
         .o_drive(w_pre[g])
      );
   end

   assign drive_out = r_drive;
   assign sync_out  = r_sync;

endmodule

// File: doc/transducer_phase_gen.md
Name: transducer_phase_gen

Overview:
Multi-channel phased square-wave generator for the levitator transducer array, directly downstream of clock_divider. Consumes clock_divider's slow clock as a step strobe and advances a shared period counter on each step. Each channel drives a 50%-duty square wave at step_rate/PERIOD, phase-shifted by a programmable offset. Offsets are written into shadow registers and committed atomically at a period boundary, so the array never shows a torn phase pattern.

Parameters:
NUM_CH, 8, number of transducer channels
PERIOD, 25, steps per output cycle (1 MHz step / 25 = 40 kHz)
CNT_W, 5, counter/phase width; must satisfy 2^CNT_W >= PERIOD
CH_W, 3, channel index width; must satisfy 2^CH_W >= NUM_CH

Ports:
clock_in  input  1  system clock; single clock domain
rst  input  1  synchronous, active-low reset; sampled on rising clock_in
tick_in  input  1  clock_slow from clock_divider; its rising edge is one step
run  input  1  level; 1 = generate, 0 = stop at the end of the current period
wr_valid  input  1  phase write request
wr_ready  output  1  phase write accept; a write occurs when wr_valid & wr_ready
wr_ch  input  CH_W  target channel
wr_phase  input  CNT_W  phase offset in steps
commit  input  1  single-cycle pulse; copy all shadows to active at next boundary
drive_out  output  NUM_CH  per-channel transducer drive
sync_out  output  1  one-cycle pulse on each period wrap
busy  output  1  state != IDLE

Behaviour:
- Reset (rst=0 at clock edge): state IDLE, cnt=0, tick_d=0, all shadow and active phases 0, commit_pending=0, drive_out=0, sync_out=0, busy=0, wr_ready=1. Reset mid-period takes effect on that edge and abandons the period.
- Step detect: tick_d <= tick_in; step = tick_in & ~tick_d. One step per tick_in rising edge, whatever its duty cycle.
- FSM:
  - IDLE -> RUN when run=1. cnt stays 0.
  - RUN: on step, cnt <= (cnt==PERIOD-1) ? 0 : cnt+1.
  - RUN -> DRAIN when run=0. In DRAIN, counting continues.
  - DRAIN -> IDLE on the wrap step (cnt goes PERIOD-1 -> 0).
  - DRAIN -> RUN if run returns to 1 before that wrap.
- Channel i: diff = (cnt >= ph_i) ? cnt - ph_i : cnt + PERIOD - ph_i.
  - drive_out[i] is registered as 1 when diff < PERIOD/2 (integer floor; 12 for 25), otherwise 0.
  - Forced 0 in IDLE.
  - drive_out changes one clock after the step that changes cnt.
- sync_out: registered; 1 for exactly one clock after every wrap step in RUN or DRAIN.
- Writes:
  - On accept, shadow[wr_ch] <= min(wr_phase, PERIOD-1) (saturate).
  - wr_ch >= NUM_CH: accepted and discarded.
  - wr_ready = ~commit_pending.
- Commit:
  - commit=1 sets commit_pending.
  - At the next wrap step, or on the following clock if in IDLE: all active <= shadow, commit_pending cleared.
  - A write accepted in the same cycle as commit is included.
  - commit while pending: no effect.
- Reset while pending: pending cleared, shadows zeroed.

Optional Feature:
PHASE_GEN_MASK_EN.
- Defined:
  - Adds input mask_valid (1) and mask_data (NUM_CH) with a shadow mask register, reset value all-ones.
  - mask_data is captured on mask_valid, committed together with the phases, and ANDed into drive_out before the output register.
- Undefined: no mask ports, and all channels are always enabled.

Decomposition:
- Package phase_gen_pkg:
  - FSM state enum (IDLE, RUN, DRAIN).
  - Default constants for PERIOD, CNT_W and NUM_CH.
  - HALF = PERIOD/2.
- Sub-module phase_gen_ch (one per channel via generate): active phase register plus modular compare, producing the pre-register drive bit.

Test Plan:
- Reset: rst=0 for 2 clocks with tick_in toggling -> drive_out=0, sync_out=0, busy=0, wr_ready=1 throughout.
- Zero phase: all phases 0, run=1, one step per 20 clocks -> every channel high for steps 0..11 and low for 12..24; sync_out pulses once per 25 steps (500 clocks).
- Offset: write ch3=5, commit, run -> ch3 rises 5 steps after ch0. Write ch3=30 -> saturates to 24.
- Atomic commit: mid-period write ch1=10, commit -> wr_ready=0 until the wrap; ch1 unchanged until cnt wraps to 0, then shifted by 10.
- Stop/drain: run=0 at cnt=7 -> counting continues to the wrap, then busy=0 and drive_out=0; run=1 re-asserted at cnt=20 -> no stop.
- Mask (PHASE_GEN_MASK_EN): mask_data=8'hF0, commit -> channels 0..3 held low after the wrap; channels 4..7 unaffected.
